// File: rtl/mouse_tracker.sv
// PS/2 mouse packet decoder: assembles 3-byte packets into a clamped cursor
// position and button state, with inter-byte timeout resynchronisation.
module mouse_tracker #(
  parameter int SCREEN_W = 640,
  parameter int SCREEN_H = 480,
  parameter int INIT_X   = 320,
  parameter int INIT_Y   = 240,
  parameter int TIMEOUT  = 2000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] rxByte,
  input  logic       rxValid,
  output logic [9:0] mouseX,
  output logic [9:0] mouseY,
  output logic       mouseLeftButton,
  output logic       mouseRightButton,
  output logic       packetValid,
  output logic       syncError
);

  localparam int CW = $clog2(TIMEOUT + 1);

  localparam logic [1:0] WAIT_B0 = 2'd0;
  localparam logic [1:0] WAIT_B1 = 2'd1;
  localparam logic [1:0] WAIT_B2 = 2'd2;

  localparam logic signed [11:0] MAX_X = 12'(SCREEN_W - 1);
  localparam logic signed [11:0] MAX_Y = 12'(SCREEN_H - 1);

  logic [1:0]    state;
  logic [CW-1:0] counter;
  logic          stLeft, stRight, stXSign, stYSign, stXOvf, stYOvf;
  logic [7:0]    byte1;

  logic                timeoutHit;
  logic [1:0]          effState;
  logic signed [11:0]  dx, dy, sumX, sumY;
  logic [9:0]          nextX, nextY;

  // A timeout in the same cycle as a strobe sends that byte down the WAIT_B0 path.
  assign timeoutHit = (state != WAIT_B0) && (counter == CW'(TIMEOUT));
  assign effState   = timeoutHit ? WAIT_B0 : state;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    dx    = '0;
    dy    = '0;
    nextX = mouseX;
    nextY = mouseY;
    if (!stXOvf) dx = {{3{stXSign}}, stXSign, byte1};
    if (!stYOvf) dy = {{3{stYSign}}, stYSign, rxByte};
    // Screen Y grows downward while PS/2 dy is positive upward.
    sumX = $signed({2'b00, mouseX}) + dx;
    sumY = $signed({2'b00, mouseY}) - dy;
    if (sumX < 12'sd0)      nextX = '0;
    else if (sumX > MAX_X)  nextX = MAX_X[9:0];
    else                    nextX = sumX[9:0];
    if (sumY < 12'sd0)      nextY = '0;
    else if (sumY > MAX_Y)  nextY = MAX_Y[9:0];
    else                    nextY = sumY[9:0];
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state            <= WAIT_B0;
      counter          <= '0;
      stLeft           <= 1'b0;
      stRight          <= 1'b0;
      stXSign          <= 1'b0;
      stYSign          <= 1'b0;
      stXOvf           <= 1'b0;
      stYOvf           <= 1'b0;
      byte1            <= '0;
      mouseX           <= 10'(INIT_X);
      mouseY           <= 10'(INIT_Y);
      mouseLeftButton  <= 1'b0;
      mouseRightButton <= 1'b0;
      packetValid      <= 1'b0;
      syncError        <= 1'b0;
    end else begin
      packetValid <= 1'b0;
      syncError   <= timeoutHit;
      if (rxValid) begin
        counter <= '0;
        case (effState)
          WAIT_B0: begin
            if (rxByte[3]) begin
              stLeft  <= rxByte[0];
              stRight <= rxByte[1];
              stXSign <= rxByte[4];
              stYSign <= rxByte[5];
              stXOvf  <= rxByte[6];
              stYOvf  <= rxByte[7];
              state   <= WAIT_B1;
            end else begin
              state     <= WAIT_B0;
              syncError <= 1'b1;
            end
          end
          WAIT_B1: begin
            byte1 <= rxByte;
            state <= WAIT_B2;
          end
          WAIT_B2: begin
            mouseX           <= nextX;
            mouseY           <= nextY;
            mouseLeftButton  <= stLeft;
            mouseRightButton <= stRight;
            packetValid      <= 1'b1;
            state            <= WAIT_B0;
          end
          default: state <= WAIT_B0;
        endcase
      end else if (timeoutHit) begin
        state   <= WAIT_B0;
        counter <= '0;
      end else if (state != WAIT_B0) begin
        counter <= counter + CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_mouse_tracker.sv
// Directed bench for mouse_tracker: a packet table walked from reset, plus
// hand sequences for discard, clamping, timeout and mid-packet reset.
module tb_mouse_tracker;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] rxByte;
  logic       rxValid;
  logic [9:0] mouseX, mouseY;
  logic       mouseLeftButton, mouseRightButton, packetValid, syncError;

  int total = 0;
  int bad = 0;
  int pvCount = 0;
  int seCount = 0;
  int pv0, se0;

  always #5 clk = ~clk;

  mouse_tracker #(.TIMEOUT(16)) dut (
    .clk(clk),
    .reset(reset),
    .rxByte(rxByte),
    .rxValid(rxValid),
    .mouseX(mouseX),
    .mouseY(mouseY),
    .mouseLeftButton(mouseLeftButton),
    .mouseRightButton(mouseRightButton),
    .packetValid(packetValid),
    .syncError(syncError)
  );

  always @(negedge clk) begin
    if (packetValid) pvCount++;
    if (syncError) seCount++;
  end

  typedef struct {
    logic [7:0] b0, b1, b2;
    int         x, y;
    logic       l, r;
  } vec_t;

  vec_t vecs[14];

  task automatic check(input string name, input int actual, input int expected);
    total++;
    if (actual != expected) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  task automatic checkOut(input string tag, input int x, input int y, input int l, input int r);
    check({tag, ".x"}, int'(mouseX), x);
    check({tag, ".y"}, int'(mouseY), y);
    check({tag, ".left"}, int'(mouseLeftButton), l);
    check({tag, ".right"}, int'(mouseRightButton), r);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic sendOne(input logic [7:0] b);
    @(negedge clk);
    rxValid = 1'b1;
    rxByte  = b;
    @(negedge clk);
    rxValid = 1'b0;
    rxByte  = 8'h00;
  endtask

  // Three strobes on consecutive cycles.
  task automatic sendPacket(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
    @(negedge clk);
    rxValid = 1'b1;
    rxByte  = a;
    @(negedge clk);
    rxByte  = b;
    @(negedge clk);
    rxByte  = c;
    @(negedge clk);
    rxValid = 1'b0;
    rxByte  = 8'h00;
    idle(2);
  endtask

  task automatic doReset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    idle(1);
  endtask

  task automatic mark();
    pv0 = pvCount;
    se0 = seCount;
  endtask

  task automatic checkPulses(input string tag, input int pv, input int se);
    check({tag, ".packetValid"}, pvCount - pv0, pv);
    check({tag, ".syncError"}, seCount - se0, se);
  endtask

  initial begin
    // Results chain from the reset position (320,240).
    vecs[0]  = '{8'h09, 8'h0A, 8'h05, 330, 235, 1'b1, 1'b0};
    vecs[1]  = '{8'h4A, 8'h7F, 8'h01, 330, 234, 1'b0, 1'b1};
    vecs[2]  = '{8'h08, 8'h10, 8'hF0, 346,   0, 1'b0, 1'b0};
    vecs[3]  = '{8'h28, 8'h00, 8'h00, 346, 256, 1'b0, 1'b0};
    vecs[4]  = '{8'h18, 8'h00, 8'h00,  90, 256, 1'b0, 1'b0};
    vecs[5]  = '{8'h18, 8'h00, 8'h00,   0, 256, 1'b0, 1'b0};
    vecs[6]  = '{8'h08, 8'hFF, 8'h00, 255, 256, 1'b0, 1'b0};
    vecs[7]  = '{8'h08, 8'hFF, 8'h00, 510, 256, 1'b0, 1'b0};
    vecs[8]  = '{8'h08, 8'hFF, 8'h00, 639, 256, 1'b0, 1'b0};
    vecs[9]  = '{8'h28, 8'h00, 8'h00, 639, 479, 1'b0, 1'b0};
    vecs[10] = '{8'h0B, 8'h00, 8'h00, 639, 479, 1'b1, 1'b1};
    vecs[11] = '{8'hC8, 8'h55, 8'h55, 639, 479, 1'b0, 1'b0};
    vecs[12] = '{8'h08, 8'h00, 8'hFF, 639, 224, 1'b0, 1'b0};
    vecs[13] = '{8'h38, 8'h01, 8'h01, 384, 479, 1'b0, 1'b0};

    reset   = 1'b1;
    rxValid = 1'b0;
    rxByte  = 8'h00;
    idle(3);
    reset = 1'b0;
    idle(1);
    checkOut("reset", 320, 240, 0, 0);
    check("reset.packetValid", int'(packetValid), 0);
    check("reset.syncError", int'(syncError), 0);

    for (int i = 0; i < 14; i++) begin
      mark();
      sendPacket(vecs[i].b0, vecs[i].b1, vecs[i].b2);
      checkOut($sformatf("vec%0d", i), vecs[i].x, vecs[i].y, int'(vecs[i].l), int'(vecs[i].r));
      checkPulses($sformatf("vec%0d", i), 1, 0);
    end

    // Left-edge clamp from the reset position.
    doReset();
    mark();
    sendPacket(8'h18, 8'h00, 8'h00);
    checkOut("dxneg1", 64, 240, 0, 0);
    sendPacket(8'h18, 8'h00, 8'h00);
    checkOut("dxneg2", 0, 240, 0, 0);
    checkPulses("dxneg", 2, 0);

    // Discarded non-status byte, then a clean packet (dy=+240 moves Y up to 0).
    doReset();
    mark();
    sendOne(8'h00);
    idle(2);
    checkPulses("discard", 0, 1);
    checkOut("discard", 320, 240, 0, 0);
    mark();
    sendPacket(8'h08, 8'h10, 8'hF0);
    checkOut("afterDiscard", 336, 0, 0, 0);
    checkPulses("afterDiscard", 1, 0);

    // Idle gap longer than the timeout abandons the packet.
    doReset();
    mark();
    sendOne(8'h08);
    idle(20);
    checkPulses("timeout", 0, 1);
    checkOut("timeout", 320, 240, 0, 0);
    sendPacket(8'h08, 8'h01, 8'h01);
    checkOut("afterTimeout", 321, 239, 0, 0);
    checkPulses("afterTimeout", 1, 1);

    // Strobe lands on the exact timeout cycle and must start a new packet.
    doReset();
    mark();
    sendOne(8'h08);
    idle(15);
    sendPacket(8'h08, 8'h01, 8'h01);
    checkOut("timeoutEdge", 321, 239, 0, 0);
    checkPulses("timeoutEdge", 1, 1);

    // Partial packet leaves outputs alone; reset beats a simultaneous strobe.
    doReset();
    sendPacket(8'h09, 8'h0A, 8'h05);
    mark();
    sendOne(8'h09);
    sendOne(8'h14);
    idle(1);
    checkOut("partial", 330, 235, 1, 0);
    @(negedge clk);
    reset   = 1'b1;
    rxValid = 1'b1;
    rxByte  = 8'h09;
    @(negedge clk);
    reset   = 1'b0;
    rxValid = 1'b0;
    rxByte  = 8'h00;
    idle(1);
    checkOut("midReset", 320, 240, 0, 0);
    checkPulses("midReset", 0, 0);
    mark();
    sendPacket(8'h08, 8'h01, 8'h01);
    checkOut("afterReset", 321, 239, 0, 0);
    checkPulses("afterReset", 1, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
